ddr_powerup_seq: RTL and testbench
==================================

DDR_POWERUP_SEQ -- requirements
Module: ddr_powerup_seq

Interface
REQ-001 Parameter NUM_RANKS, default 2: number of ranks driven, legal range 1..4.
REQ-002 Parameter CNT_W, default 16: width of the internal timing counter.
REQ-003 Parameter T_RESET_LOW, default 200: clock cycles ddr_reset_n is held low.
REQ-004 Parameter T_CKE_DLY, default 500: cycles from ddr_reset_n rising to first CKE assertion.
REQ-005 Parameter T_XPR, default 10: cycles from the last CKE assertion to init_done.
REQ-006 Parameter STAGGER_DLY, default 4: cycles between successive rank CKE assertions.
REQ-007 clock  in  1  single clock domain for the whole block.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle request to begin or restart the power-up sequence.
REQ-010 abort  in  1  forces the sequence back to IDLE with the DRAM held in reset.
REQ-011 rank_en  in  NUM_RANKS  per-rank enable, sampled on an accepted start.
REQ-012 ddr_reset_n  out  1  active-low DRAM reset.
REQ-013 cke  out  NUM_RANKS  per-rank clock enable.
REQ-014 busy  out  1  high in RST_LOW, CKE_WAIT and XPR_WAIT.
REQ-015 init_done  out  1  high only in DONE.

Function
REQ-016 The FSM SHALL have the states IDLE, RST_LOW, CKE_WAIT, XPR_WAIT and DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE, start with a nonzero rank_en SHALL move the FSM to RST_LOW on the next edge, latch rank_en and load the counter.
REQ-018 start with rank_en equal to all zeros SHALL be ignored.
REQ-019 start while busy is high SHALL be ignored.
REQ-020 RST_LOW SHALL last exactly T_RESET_LOW cycles with ddr_reset_n=0 and cke=0.
REQ-021 CKE_WAIT SHALL last exactly T_CKE_DLY cycles with ddr_reset_n=1 and cke=0.
REQ-022 On entry to XPR_WAIT, cke SHALL assert for the enabled ranks only; cke for disabled ranks SHALL stay 0.
REQ-023 XPR_WAIT SHALL last T_XPR cycles counted from the last enabled rank's CKE assertion, then the FSM SHALL enter DONE.
REQ-024 In DONE: ddr_reset_n=1, cke equals the latched rank_en, init_done=1; these values SHALL hold until start, abort or reset.
REQ-025 abort SHALL take the FSM to IDLE on the next edge from any state, with ddr_reset_n=0 and cke=0; abort SHALL take priority over a simultaneous start.
REQ-026 The counter SHALL count down and SHALL NOT wrap; each timing parameter SHALL fit in CNT_W bits and be at least 1, checked by an elaboration-time assertion.

Reset
REQ-027 While reset is high: state=IDLE, ddr_reset_n=0, cke=0, busy=0, init_done=0, counter=0, latched rank_en=0.
REQ-028 Reset asserted mid-sequence SHALL override start and abort in the same cycle.

Configuration
REQ-029 With DDR_CKE_STAGGER_EN defined, enabled ranks SHALL assert CKE in ascending index order, STAGGER_DLY cycles apart, the first on XPR_WAIT entry.
REQ-030 Without DDR_CKE_STAGGER_EN, all enabled ranks SHALL assert CKE on the same cycle and STAGGER_DLY SHALL be unused.

Structure
REQ-031 ddr_package SHALL hold the state enum type and the default timing constants.
REQ-032 The loadable down-counter SHALL be a sub-module named ddr_seq_counter, with inputs load, load_val and en and output zero.

Verification
REQ-033 Reset, then start with rank_en=2'b11 and defaults -> ddr_reset_n low 200 cycles, high; both cke high 500 cycles later (no stagger); init_done 10 cycles after that.
REQ-034 DDR_CKE_STAGGER_EN, rank_en=2'b11 -> cke[1] rises 4 cycles after cke[0]; init_done 10 cycles after cke[1].
REQ-035 rank_en=2'b10 -> cke[0] stays 0 throughout; rank_en=2'b00 -> start ignored, busy stays 0.
REQ-036 abort 50 cycles into CKE_WAIT -> next edge: IDLE, ddr_reset_n=0, cke=0, busy=0; a later start runs the full sequence.
REQ-037 start pulsed during RST_LOW -> ignored, timing unchanged; start in DONE -> init_done=0 and ddr_reset_n=0 on the next edge.
REQ-038 reset asserted during XPR_WAIT together with start -> all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/ddr_package.sv
// Shared state encoding, default timing constants and rank-selection helper
// for the DDR power-up sequencer.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : ddr_package                                                |
// | Description : State enum, default timings, lowest-set-bit helper.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ddr_package;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RST_LOW   = 3'd1,
      S_CKE_WAIT  = 3'd2,
      S_XPR_WAIT  = 3'd3,
      S_DONE      = 3'd4
   } state_e;

   localparam int c_max_ranks         = 4;
   localparam int c_def_num_ranks     = 2;
   localparam int c_def_cnt_w         = 16;
   localparam int c_def_t_reset_low   = 200;
   localparam int c_def_t_cke_dly     = 500;
   localparam int c_def_t_xpr         = 10;
   localparam int c_def_stagger_dly   = 4;

   // Isolates the lowest set bit: used to walk enabled ranks in index order.
   function automatic logic [c_max_ranks-1:0] lowest_set(input logic [c_max_ranks-1:0] v);
      return v & (~v + 1'b1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_seq_counter.sv
// Loadable, saturating down-counter used to time each sequencer phase.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : ddr_seq_counter                                            |
// | Description : Down-counter with synchronous load; stops at zero.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ddr_seq_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (en && (count_q != '0))
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/ddr_powerup_seq.sv
// DDR power-up sequencer: reset low, CKE delay, per-rank CKE, tXPR, done.
// Optional staggered per-rank CKE when DDR_CKE_STAGGER_EN is defined.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : ddr_powerup_seq                                            |
// | Description : DRAM reset/CKE power-up FSM. Macro DDR_CKE_STAGGER_EN      |
// |               staggers rank CKE assertions STAGGER_DLY cycles apart.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ddr_powerup_seq
   import ddr_package::*;
#(
   parameter int NUM_RANKS   = c_def_num_ranks,
   parameter int CNT_W       = c_def_cnt_w,
   parameter int T_RESET_LOW = c_def_t_reset_low,
   parameter int T_CKE_DLY   = c_def_t_cke_dly,
   parameter int T_XPR       = c_def_t_xpr,
   parameter int STAGGER_DLY = c_def_stagger_dly
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_RANKS-1:0] rank_en,
   output logic                 ddr_reset_n,
   output logic [NUM_RANKS-1:0] cke,
   output logic                 busy,
   output logic                 init_done
);

   if (NUM_RANKS < 1 || NUM_RANKS > c_max_ranks || CNT_W < 2 || CNT_W > 31
       || T_RESET_LOW < 1 || T_RESET_LOW > (2**CNT_W) - 1
       || T_CKE_DLY   < 1 || T_CKE_DLY   > (2**CNT_W) - 1
       || T_XPR       < 1 || T_XPR       > (2**CNT_W) - 1
       || STAGGER_DLY < 1 || STAGGER_DLY > (2**CNT_W) - 1) begin : g_bad_param
      $error("ddr_powerup_seq: parameter out of range");
   end

   // Counter is loaded with duration-1 so a phase lasts exactly its duration.
   localparam logic [CNT_W-1:0] c_ld_rst = CNT_W'(T_RESET_LOW - 1);
   localparam logic [CNT_W-1:0] c_ld_cke = CNT_W'(T_CKE_DLY - 1);
   localparam logic [CNT_W-1:0] c_ld_xpr = CNT_W'(T_XPR - 1);

   state_e               state_q, state_d;
   logic [NUM_RANKS-1:0] rank_q, rank_d;
   logic [NUM_RANKS-1:0] cke_q, cke_d;
   logic                 ddr_reset_n_q, ddr_reset_n_d;
   logic                 busy_q, busy_d;
   logic                 init_done_q, init_done_d;
   logic                 cnt_load, cnt_zero;
   logic [CNT_W-1:0]     cnt_load_val;

`ifdef DDR_CKE_STAGGER_EN
   localparam logic [CNT_W-1:0] c_ld_stg = CNT_W'(STAGGER_DLY - 1);
   logic [c_max_ranks-1:0] first_w, next_w;
   logic [NUM_RANKS-1:0]   first_rank, next_rank, pending;

   assign pending    = rank_q & ~cke_q;
   assign first_w    = lowest_set(c_max_ranks'(rank_q));
   assign next_w     = lowest_set(c_max_ranks'(pending));
   assign first_rank = first_w[NUM_RANKS-1:0];
   assign next_rank  = next_w[NUM_RANKS-1:0];
`endif

   ddr_seq_counter #(.CNT_W(CNT_W)) u_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (busy_q),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      rank_d       = rank_q;
      cke_d        = cke_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && (rank_en != '0)) begin
               state_d      = S_RST_LOW;
               rank_d       = rank_en;
               cnt_load     = 1'b1;
               cnt_load_val = c_ld_rst;
            end
         end
         S_RST_LOW: begin
            if (cnt_zero) begin
               state_d      = S_CKE_WAIT;
               cnt_load     = 1'b1;
               cnt_load_val = c_ld_cke;
            end
         end
         S_CKE_WAIT: begin
            if (cnt_zero) begin
               state_d  = S_XPR_WAIT;
               cnt_load = 1'b1;
`ifdef DDR_CKE_STAGGER_EN
               cke_d        = first_rank;
               cnt_load_val = (rank_q == first_rank) ? c_ld_xpr : c_ld_stg;
`else
               cke_d        = rank_q;
               cnt_load_val = c_ld_xpr;
`endif
            end
         end
         S_XPR_WAIT: begin
            if (cnt_zero) begin
`ifdef DDR_CKE_STAGGER_EN
               // tXPR only starts once the final enabled rank has CKE high.
               if (pending != '0) begin
                  cke_d        = cke_q | next_rank;
                  cnt_load     = 1'b1;
                  cnt_load_val = ((pending & ~next_rank) == '0) ? c_ld_xpr : c_ld_stg;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d  = S_IDLE;
         cnt_load = 1'b0;
      end

      ddr_reset_n_d = (state_d == S_CKE_WAIT) || (state_d == S_XPR_WAIT) || (state_d == S_DONE);
      busy_d        = (state_d == S_RST_LOW) || (state_d == S_CKE_WAIT) || (state_d == S_XPR_WAIT);
      init_done_d   = (state_d == S_DONE);
      if (state_d == S_DONE)
         cke_d = rank_d;
      else if (state_d != S_XPR_WAIT)
         cke_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rank_q        <= '0;
         cke_q         <= '0;
         ddr_reset_n_q <= 1'b0;
         busy_q        <= 1'b0;
         init_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rank_q        <= rank_d;
         cke_q         <= cke_d;
         ddr_reset_n_q <= ddr_reset_n_d;
         busy_q        <= busy_d;
         init_done_q   <= init_done_d;
      end
   end

   assign ddr_reset_n = ddr_reset_n_q;
   assign cke         = cke_q;
   assign busy        = busy_q;
   assign init_done   = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_powerup_seq.sv
// Self-checking bench for ddr_powerup_seq against a timeline model.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : tb_ddr_powerup_seq                                         |
// | Description : Directed + randomized checks of the power-up timeline.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ddr_powerup_seq;

   localparam int NR = 2;
   localparam int TR = 200;
   localparam int TC = 500;
   localparam int TX = 10;
   localparam int SD = 4;
`ifdef DDR_CKE_STAGGER_EN
   localparam bit STG = 1'b1;
`else
   localparam bit STG = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NR-1:0] rank_en = '0;
   logic          ddr_reset_n;
   logic [NR-1:0] cke;
   logic          busy;
   logic          init_done;

   int checks   = 0;
   int failures = 0;

   ddr_powerup_seq #(
      .NUM_RANKS(NR), .CNT_W(16), .T_RESET_LOW(TR), .T_CKE_DLY(TC),
      .T_XPR(TX), .STAGGER_DLY(SD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .rank_en     (rank_en),
      .ddr_reset_n (ddr_reset_n),
      .cke         (cke),
      .busy        (busy),
      .init_done   (init_done)
   );

   always #5 clock = ~clock;

   // Packed view: {ddr_reset_n, cke, busy, init_done}
   localparam logic [NR+2:0] QUIET = '0;

   function automatic logic [NR+2:0] snap();
      return {ddr_reset_n, cke, busy, init_done};
   endfunction

   // Cycle (relative to the accepting edge) at which each enabled rank's CKE rises.
   function automatic int cke_time(input logic [NR-1:0] en, input int k);
      int j = 0;
      for (int i = 0; i < k; i++)
         if (en[i]) j++;
      return TR + TC + (STG ? j * SD : 0);
   endfunction

   function automatic int done_time(input logic [NR-1:0] en);
      int last = 0;
      for (int k = 0; k < NR; k++)
         if (en[k]) last = cke_time(en, k);
      return last + TX;
   endfunction

   function automatic logic [NR+2:0] expect_at(input int t, input logic [NR-1:0] en);
      logic [NR-1:0] c = '0;
      if (t < TR)
         return {1'b0, {NR{1'b0}}, 1'b1, 1'b0};
      if (t >= done_time(en))
         return {1'b1, en, 1'b0, 1'b1};
      for (int k = 0; k < NR; k++)
         c[k] = en[k] && (t >= cke_time(en, k));
      return {1'b1, c, 1'b1, 1'b0};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [NR+2:0] obs, input logic [NR+2:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Pulses start with en, then checks cycles t=0..tmax-1; returns positioned at t=tmax.
   task automatic run_seq(input logic [NR-1:0] en, input int tmax, input bit noise, input string tag);
      int dt = done_time(en);
      start   = 1'b1;
      rank_en = en;
      step();
      start = 1'b0;
      for (int t = 0; t < tmax; t++) begin
         check($sformatf("%s t=%0d", tag, t), snap(), expect_at(t, en));
         if (noise && t < dt) begin
            start   = ($urandom_range(0, 7) == 0);
            rank_en = NR'($urandom);
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      logic [NR-1:0] en;

      repeat (3) step();
      check("reset_values", snap(), QUIET);
      reset = 1'b0;
      step();
      check("idle_after_reset", snap(), QUIET);

      start   = 1'b1;
      rank_en = 2'b00;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("zero_rank_start i=%0d", i), snap(), QUIET);
         step();
      end

      run_seq(2'b11, done_time(2'b11) + 4, 1'b0, "seq_11");
      run_seq(2'b10, done_time(2'b10) + 4, 1'b0, "seq_10_from_done");
      run_seq(2'b01, done_time(2'b01) + 3, 1'b1, "seq_01_noise");

      for (int r = 0; r < 3; r++) begin
         en = NR'($urandom_range(1, 3));
         run_seq(en, done_time(en) + 3, 1'b1, $sformatf("rand%0d_en%b", r, en));
      end

      // Abort 50 cycles into CKE_WAIT, with a simultaneous start that must lose.
      run_seq(2'b11, TR + 50, 1'b0, "pre_abort");
      abort   = 1'b1;
      start   = 1'b1;
      rank_en = 2'b11;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("abort_next_edge", snap(), QUIET);
      step();
      check("abort_stays_idle", snap(), QUIET);
      run_seq(2'b11, done_time(2'b11) + 3, 1'b0, "post_abort");

      // Reset during XPR_WAIT together with start.
      run_seq(2'b11, TR + TC + 2, 1'b0, "pre_reset");
      reset = 1'b1;
      start = 1'b1;
      step();
      check("reset_in_xpr", snap(), QUIET);
      reset = 1'b0;
      start = 1'b0;
      step();
      check("idle_after_mid_reset", snap(), QUIET);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
